alu_op_sequencer: RTL and testbench

- Issue/retire stage that sits directly upstream and downstream of the 64-bit registered ALU (ALU64bit).
- Accepts operations (A, B, opcode, tag) over a valid/ready interface, registers them onto the ALU inputs, and tracks each operation through the ALU's fixed register latency.
- Captures Z, carry and overflow with the matching tag into a result FIFO, drained over a valid/ready interface.
- Credit-based issue guarantees that no ALU result is ever dropped.

---
 rtl/alu_op_sequencer.sv | 172 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Issue/retire wrapper around a fixed-latency registered 64-bit ALU: credit-based issue,
// tag tracking pipe and FWFT result FIFO. Optional sticky overflow via ALU_SEQ_STICKY_OVF_EN.
module alu_op_sequencer #(
  parameter int unsigned ALU_LAT = 2,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_a,
  input  logic [63:0]      in_b,
  input  logic [3:0]       in_opcode,
  input  logic [TAG_W-1:0] in_tag,
  output logic [63:0]      alu_a,
  output logic [63:0]      alu_b,
  output logic [3:0]       alu_opcode,
  input  logic [63:0]      alu_z,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_z,
  output logic             out_carry,
  output logic             out_overflow,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
`ifdef ALU_SEQ_STICKY_OVF_EN
  ,
  output logic             sticky_ovf,
  input  logic             sticky_clr
`endif
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned SumW = $clog2(DEPTH + ALU_LAT + 2);

  typedef struct packed {
    logic [63:0]      z;
    logic             carry;
    logic             ovf;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [ALU_LAT:0]            vpipe_q, vpipe_d;
  logic [ALU_LAT:0][TAG_W-1:0] tpipe_q, tpipe_d;
  entry_t                      mem_q [DEPTH];
  logic [PtrW-1:0]             rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, head_idx;
  logic [CntW-1:0]             count_q, count_d;
  logic [63:0]                 alu_a_q, alu_b_q;
  logic [3:0]                  alu_opcode_q;
  logic [SumW-1:0]             inflight, occupancy;
  logic                        issue, fifo_wr, fifo_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i <= int'(ALU_LAT); i++) begin
      inflight = inflight + SumW'(vpipe_q[i]);
    end
  end

  // Credits count registered state only, so a pop frees its slot one cycle later.
  assign occupancy = inflight + SumW'(count_q);
  assign in_ready  = occupancy < SumW'(DEPTH);
  assign issue     = in_valid && in_ready;
  assign fifo_wr   = vpipe_q[ALU_LAT];
  assign out_valid = count_q != '0;
  assign fifo_pop  = out_valid && out_ready;
  assign busy      = (inflight != '0) || (count_q != '0);

  always_comb begin
    vpipe_d    = '0;
    tpipe_d    = '0;
    vpipe_d[0] = issue;
    tpipe_d[0] = in_tag;
    for (int i = 1; i <= int'(ALU_LAT); i++) begin
      vpipe_d[i] = vpipe_q[i-1];
      tpipe_d[i] = tpipe_q[i-1];
    end
  end

  always_comb begin
    rd_ptr_d = fifo_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = fifo_wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    count_d  = count_q;
    unique case ({fifo_wr, fifo_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vpipe_q      <= '0;
      tpipe_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_opcode_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      vpipe_q  <= vpipe_d;
      tpipe_q  <= tpipe_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (issue) begin
        alu_a_q      <= in_a;
        alu_b_q      <= in_b;
        alu_opcode_q <= in_opcode;
      end
      if (fifo_wr) begin
        mem_q[wr_ptr_q] <= '{z: alu_z, carry: alu_carry, ovf: alu_overflow,
                             tag: tpipe_q[ALU_LAT]};
      end
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_opcode_q;

  // While empty, show the most recently popped slot so the data fields hold steady.
  always_comb begin
    head_idx = rd_ptr_q;
    if (!out_valid) begin
      head_idx = (rd_ptr_q == '0) ? PtrW'(DEPTH - 1) : rd_ptr_q - PtrW'(1);
    end
  end

  assign out_z        = mem_q[head_idx].z;
  assign out_carry    = mem_q[head_idx].carry;
  assign out_overflow = mem_q[head_idx].ovf;
  assign out_tag      = mem_q[head_idx].tag;

`ifdef ALU_SEQ_STICKY_OVF_EN
  logic sticky_q, sticky_d;

  always_comb begin
    sticky_d = sticky_q;
    if (fifo_pop && mem_q[rd_ptr_q].ovf) begin
      sticky_d = 1'b1;
    end else if (sticky_clr) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_ovf = sticky_q;
`else
  // No sticky overflow state in this build.
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: behavioural two-stage ALU plus a queue-based model
// of accepted operations; define ALU_SEQ_STICKY_OVF_EN to also check the sticky overflow flag.
module tb_alu_op_sequencer;

  localparam int ALU_LAT = 2;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;

  logic             clk, rst;
  logic             in_valid, in_ready;
  logic [63:0]      in_a, in_b;
  logic [3:0]       in_opcode;
  logic [TAG_W-1:0] in_tag;
  logic [63:0]      alu_a, alu_b, alu_z;
  logic [3:0]       alu_opcode;
  logic             alu_carry, alu_overflow;
  logic             out_valid, out_ready, out_carry, out_overflow, busy;
  logic [63:0]      out_z;
  logic [TAG_W-1:0] out_tag;
  logic             sticky_ovf, sticky_clr;

  alu_op_sequencer #(.ALU_LAT(ALU_LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_opcode(in_opcode), .in_tag(in_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_z(alu_z), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_carry(out_carry),
    .out_overflow(out_overflow), .out_tag(out_tag), .busy(busy)
`ifdef ALU_SEQ_STICKY_OVF_EN
    , .sticky_ovf(sticky_ovf), .sticky_clr(sticky_clr)
`endif
  );

`ifndef ALU_SEQ_STICKY_OVF_EN
  assign sticky_ovf = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {z, carry, overflow}; 1000 add, 1001 sub (carry = borrow), 0000/0001/0010 logic.
  function automatic logic [65:0] alu_ref(input logic [63:0] a, input logic [63:0] b,
                                          input logic [3:0] op);
    logic [64:0] s;
    logic [63:0] z;
    logic        c, o;
    c = 1'b0;
    o = 1'b0;
    s = '0;
    case (op)
      4'b1000: begin
        s = {1'b0, a} + {1'b0, b};
        z = s[63:0];
        c = s[64];
        o = (a[63] == b[63]) && (z[63] != a[63]);
      end
      4'b1001: begin
        s = {1'b0, a} - {1'b0, b};
        z = s[63:0];
        c = s[64];
        o = (a[63] != b[63]) && (z[63] != a[63]);
      end
      4'b0000: z = a & b;
      4'b0001: z = a | b;
      4'b0010: z = a ^ b;
      default: z = a;
    endcase
    return {z, c, o};
  endfunction

  logic [65:0] s1_q, s2_q;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= alu_ref(alu_a, alu_b, alu_opcode);
      s2_q <= s1_q;
    end
  end
  assign {alu_z, alu_carry, alu_overflow} = s2_q;

  typedef struct {
    logic [63:0]      z;
    logic             c;
    logic             o;
    logic [TAG_W-1:0] tag;
    int               t;
  } exp_t;

  exp_t             q[$];
  int               cyc, vectors, miscompares;
  logic [63:0]      last_z;
  logic [TAG_W-1:0] last_tag;
  logic             sticky_exp;
  logic [3:0]       ops [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b1000, 4'b1001};

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", name, obs, exp);
    end
  endtask

  function automatic bit exp_valid();
    return (q.size() > 0) && ((cyc - q[0].t) >= ALU_LAT + 1);
  endfunction

  task automatic check_outputs();
    chk("in_ready", in_ready, q.size() < DEPTH);
    chk("out_valid", out_valid, exp_valid());
    chk("busy", busy, q.size() != 0);
    if (exp_valid()) begin
      chk("out_z", out_z, q[0].z);
      chk("out_carry", out_carry, q[0].c);
      chk("out_overflow", out_overflow, q[0].o);
      chk("out_tag", out_tag, q[0].tag);
    end else begin
      chk("hold_z", out_z, last_z);
      chk("hold_tag", out_tag, last_tag);
    end
    chk("full_write", dut.fifo_wr && (dut.count_q == DEPTH), 1'b0);
`ifdef ALU_SEQ_STICKY_OVF_EN
    chk("sticky_ovf", sticky_ovf, sticky_exp);
`endif
  endtask

  // Check at negedge, then advance the model across the next rising edge.
  task automatic cycle(output bit acc);
    bit   fire_out;
    exp_t e;
    @(negedge clk);
    check_outputs();
    acc      = in_valid && (q.size() < DEPTH);
    fire_out = out_ready && exp_valid();
    @(posedge clk);
    cyc++;
    if (fire_out) begin
      last_z   = q[0].z;
      last_tag = q[0].tag;
      if (q[0].o) sticky_exp = 1'b1;
      else if (sticky_clr) sticky_exp = 1'b0;
      void'(q.pop_front());
    end else if (sticky_clr) begin
      sticky_exp = 1'b0;
    end
    if (acc) begin
      {e.z, e.c, e.o} = alu_ref(in_a, in_b, in_opcode);
      e.tag = in_tag;
      e.t   = cyc;
      q.push_back(e);
    end
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    in_valid = 1'b0;
    repeat (n) cycle(acc);
  endtask

  task automatic send_op(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op,
                         input logic [TAG_W-1:0] tag);
    bit acc;
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_opcode = op;
    in_tag    = tag;
    acc       = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) cycle(acc);
    chk("issue_accepted", acc, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) idle(1);
    idle(1);
    chk("drained_busy", busy, 1'b0);
  endtask

  task automatic stream(input int n);
    logic [63:0] a, b;
    for (int k = 0; k < n; k++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) a = 64'h7FFF_FFFF_FFFF_FFFF;
      if ($urandom_range(0, 3) == 0) b = 64'hFFFF_FFFF_FFFF_FFFF;
      send_op(a, b, ops[$urandom_range(0, 4)], TAG_W'(k));
    end
    drain();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst      = 1'b1;
    q.delete();
    last_z     = '0;
    last_tag   = '0;
    sticky_exp = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_alu_a", alu_a, 64'd0);
    chk("rst_alu_opcode", alu_opcode, 4'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int acc_cnt;
  bit acc;

  initial begin
    vectors = 0; miscompares = 0; cyc = 0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_opcode = '0; in_tag = '0;
    out_ready = 1'b0; sticky_clr = 1'b0;
    last_z = '0; last_tag = '0; sticky_exp = 1'b0;
    rst = 1'b1;
    #1;
    chk("init_alu_b", alu_b, 64'd0);
    chk("init_out_valid", out_valid, 1'b0);
    chk("init_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Latency and add
    out_ready = 1'b1;
    send_op(64'd5, 64'd7, 4'b1000, 4'd3);
    idle(3);
    chk("lat_valid", out_valid, 1'b1);
    chk("lat_z", out_z, 64'd12);
    chk("lat_tag", out_tag, 4'd3);
    drain();

    // Signed overflow and sticky flag
    send_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'b1000, 4'd5);
    idle(3);
    chk("ovf_z", out_z, 64'h8000_0000_0000_0000);
    chk("ovf_flag", out_overflow, 1'b1);
    chk("ovf_carry", out_carry, 1'b0);
    idle(1);
`ifdef ALU_SEQ_STICKY_OVF_EN
    chk("sticky_set", sticky_ovf, 1'b1);
    sticky_clr = 1'b1;
    idle(1);
    sticky_clr = 1'b0;
    chk("sticky_cleared", sticky_ovf, 1'b0);
`endif
    drain();

    // Backpressure: only DEPTH credits
    out_ready = 1'b0;
    acc_cnt   = 0;
    in_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_a = 64'(i); in_b = 64'd100; in_opcode = 4'b1000; in_tag = TAG_W'(acc_cnt);
      cycle(acc);
      if (acc) acc_cnt++;
    end
    in_valid = 1'b0;
    chk("bp_accepted", acc_cnt, 4);
    chk("bp_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    send_op(64'd4, 64'd100, 4'b1000, 4'd4);
    send_op(64'd5, 64'd100, 4'b1000, 4'd5);
    drain();

    // Streaming, then a longer stream wrapping the FIFO pointers repeatedly
    stream(20);
    stream(24);

    // Reset with operations in flight
    out_ready = 1'b1;
    send_op(64'd10, 64'd3, 4'b1001, 4'd1);
    send_op(64'd11, 64'd3, 4'b1001, 4'd2);
    send_op(64'd12, 64'd3, 4'b1001, 4'd3);
    do_reset();
    idle(8);
    send_op(64'd1, 64'd1, 4'b1001, 4'd7);
    idle(3);
    chk("post_rst_valid", out_valid, 1'b1);
    chk("post_rst_z", out_z, 64'd0);
    chk("post_rst_tag", out_tag, 4'd7);
    drain();

    // Random ready toggling
    for (int k = 0; k < 30; k++) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
      in_opcode = ops[$urandom_range(0, 4)]; in_tag = TAG_W'($urandom);
      cycle(acc);
    end
    out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
